halt_ctrl: RTL and testbench

Simulation/bring-up halt controller that sits on the `single_cycle_cpu` data-memory write bus and is the CPU-facing end of the run/stop interface. The CPU reports completion by storing to a `tohost` address. A watchdog or an external request can also stop the run. The block then drains, asserts `halt` back to the CPU, and latches an exit code, pass flag and cycle count for the bench to check.

---
 rtl/halt_ctrl_pkg.sv | 17 +
 rtl/halt_ctrl.sv | 125 ++++++++++++
 tb/tb_halt_ctrl.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/halt_ctrl_pkg.sv
// Shared types and constants for the halt controller.
package halt_ctrl_pkg;

    // Run/stop state of the controller.
    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_HALTED = 2'd2
    } state_t;

    // Word address a program stores to when it exits.
    localparam logic [31:0] TOHOST_ADDR_DEFAULT = 32'h0000_1000;

    // Exit store data that marks a passing run.
    localparam logic [31:0] PASS_VALUE = 32'h0000_0001;

endpackage

// File: rtl/halt_ctrl.sv
// Halt controller: watches the CPU store bus for a tohost exit, an external
// stop request or a watchdog expiry, drains for a fixed number of cycles with
// halt asserted, then reports done with the latched exit information.
//
// Handshake: there is no valid/ready pair here. A store is taken as an event
// in the cycle mem_we is high; ext_halt_req is a level sampled every RUN cycle.
module halt_ctrl
    import halt_ctrl_pkg::*;
#(
    parameter logic [31:0] TOHOST_ADDR    = TOHOST_ADDR_DEFAULT,
    parameter logic [31:0] TIMEOUT_CYCLES = 32'd2000,
    parameter int unsigned DRAIN_CYCLES   = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_we,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic        ext_halt_req,
    output logic        halt,
    output logic        done,
    output logic [30:0] exit_code,
    output logic        pass,
    output logic        timeout,
    output logic [31:0] cycle_count
);

    // Drain counter starts at DRAIN_CYCLES-1 so done follows halt by
    // exactly DRAIN_CYCLES edges.
    localparam logic [7:0]  DRAIN_LOAD = 8'(DRAIN_CYCLES - 1);
    localparam logic [31:0] WDOG_LAST  = TIMEOUT_CYCLES - 32'd1;

    state_t      state;
    state_t      state_nxt;
    logic [7:0]  drain_cnt;
    logic        load_drain;

    logic        exit_store;
    logic        wdog_hit;
    logic        stop_any;

    // Event decode; only meaningful while in RUN.
    assign exit_store = mem_we && (mem_addr == TOHOST_ADDR) && mem_wdata[0];
    assign wdog_hit   = (TIMEOUT_CYCLES != 32'd0) && (cycle_count == WDOG_LAST);
    assign stop_any   = exit_store || ext_halt_req || wdog_hit;

    // halt and done are decoded straight from the state flop, so they carry
    // no combinational path from any input.
    assign halt = (state != ST_RUN);
    assign done = (state == ST_HALTED);

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_RUN;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic and drain-counter load request.
    always_comb begin
        state_nxt  = state;
        load_drain = 1'b0;
        case (state)
            ST_RUN: begin
                if (stop_any) begin
                    state_nxt  = ST_DRAIN;
                    load_drain = 1'b1;
                end
            end
            ST_DRAIN: begin
                if (drain_cnt == 8'd0) begin
                    state_nxt = ST_HALTED;
                end
            end
            ST_HALTED: begin
                state_nxt = ST_HALTED;
            end
            default: begin
                state_nxt = ST_RUN;
            end
        endcase
    end

    // Drain down-counter: loaded on the stop edge, counts down in DRAIN.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            drain_cnt <= 8'd0;
        end else if (load_drain) begin
            drain_cnt <= DRAIN_LOAD;
        end else if ((state == ST_DRAIN) && (drain_cnt != 8'd0)) begin
            drain_cnt <= drain_cnt - 8'd1;
        end
    end

    // Run-cycle counter; the increment at the stop edge is kept, then it freezes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cycle_count <= 32'd0;
        end else if (state == ST_RUN) begin
            cycle_count <= cycle_count + 32'd1;
        end
    end

    // Result latch: only the highest-priority stop event updates the outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            exit_code <= 31'd0;
            pass      <= 1'b0;
            timeout   <= 1'b0;
        end else if (state == ST_RUN) begin
            if (exit_store) begin
                exit_code <= mem_wdata[31:1];
                pass      <= (mem_wdata == PASS_VALUE);
            end else if (ext_halt_req) begin
                exit_code <= 31'd0;
                pass      <= 1'b0;
            end else if (wdog_hit) begin
                timeout   <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_halt_ctrl.sv
// Directed bench for halt_ctrl: exit stores, ignore rules, watchdog,
// event priority, reset during DRAIN, and a disabled watchdog.
module tb_halt_ctrl;
    import halt_ctrl_pkg::*;

    localparam logic [31:0] TOHOST = 32'h0000_1000;

    logic        clk;
    logic        rst;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        ext_halt_req;
    logic        halt;
    logic        done;
    logic [30:0] exit_code;
    logic        pass;
    logic        timeout;
    logic [31:0] cycle_count;

    logic        rst_z;
    logic        halt_z;
    logic        done_z;
    logic [30:0] exit_code_z;
    logic        pass_z;
    logic        timeout_z;
    logic [31:0] cycle_count_z;

    int          total;
    int          bad;
    int          z_edges;
    logic        z_seen_halt;

    // Expected result: {exit_code[30:0], pass, timeout, cycle_count[31:0]}
    logic [64:0] exp_q[$];

    halt_ctrl #(
        .TOHOST_ADDR    (TOHOST),
        .TIMEOUT_CYCLES (32'd50),
        .DRAIN_CYCLES   (2)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .ext_halt_req (ext_halt_req),
        .halt         (halt),
        .done         (done),
        .exit_code    (exit_code),
        .pass         (pass),
        .timeout      (timeout),
        .cycle_count  (cycle_count)
    );

    halt_ctrl #(
        .TOHOST_ADDR    (TOHOST),
        .TIMEOUT_CYCLES (32'd0),
        .DRAIN_CYCLES   (2)
    ) dut_z (
        .clk          (clk),
        .rst          (rst_z),
        .mem_we       (1'b0),
        .mem_addr     (32'd0),
        .mem_wdata    (32'd0),
        .ext_halt_req (1'b0),
        .halt         (halt_z),
        .done         (done_z),
        .exit_code    (exit_code_z),
        .pass         (pass_z),
        .timeout      (timeout_z),
        .cycle_count  (cycle_count_z)
    );

    // Clock and reset-free edge tracking
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) begin
        if (!rst_z) z_edges = z_edges + 1;
    end

    always @(negedge clk) begin
        if (halt_z) z_seen_halt = 1'b1;
    end

    task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic drive_idle();
        mem_we       = 1'b0;
        mem_addr     = 32'd0;
        mem_wdata    = 32'd0;
        ext_halt_req = 1'b0;
    endtask

    task automatic drive_store(input logic [31:0] addr, input logic [31:0] data);
        mem_we    = 1'b1;
        mem_addr  = addr;
        mem_wdata = data;
    endtask

    task automatic do_reset();
        drive_idle();
        rst = 1'b1;
        repeat (3) step();
        chk("reset_outs", 72'({halt, done, exit_code, pass, timeout, cycle_count}), 72'd0);
        rst = 1'b0;
    endtask

    // Run free until cycle_count reads target (bounded).
    task automatic run_to(input logic [31:0] target);
        int guard;
        guard = 0;
        while (cycle_count != target && guard < 200) begin
            step();
            guard++;
        end
        chk("run_to", 72'(cycle_count), 72'(target));
    endtask

    // Called at the first negedge with halt high; follows DRAIN into HALTED.
    task automatic check_drain(input string tag, input bit drain_store);
        logic [64:0] exp;
        chk({tag, "_halt"}, 72'({halt, done}), 72'b10);
        drive_idle();
        if (drain_store) drive_store(TOHOST, PASS_VALUE);
        step();
        drive_idle();
        chk({tag, "_drain"}, 72'({halt, done}), 72'b10);
        step();
        chk({tag, "_done"}, 72'({halt, done}), 72'b11);
        if (exp_q.size() == 0) begin
            chk({tag, "_q_empty"}, 72'd1, 72'd0);
        end else begin
            exp = exp_q.pop_front();
            chk({tag, "_result"}, 72'({exit_code, pass, timeout, cycle_count}), 72'(exp));
            drive_store(TOHOST, 32'h0000_00FF);
            ext_halt_req = 1'b1;
            step();
            step();
            drive_idle();
            chk({tag, "_hold"}, 72'({halt, done, exit_code, pass, timeout, cycle_count}),
                72'({2'b11, exp}));
        end
    endtask

    initial begin
        int n;
        total       = 0;
        bad         = 0;
        z_edges     = 0;
        z_seen_halt = 1'b0;
        rst_z       = 1'b1;
        drive_idle();

        // Passing exit at RUN cycle 10
        do_reset();
        rst_z = 1'b0;
        for (int k = 1; k <= 9; k++) begin
            step();
            chk("count_up", 72'({halt, cycle_count}), 72'({1'b0, 32'(k)}));
        end
        drive_store(TOHOST, 32'h1);
        exp_q.push_back({31'd0, 1'b1, 1'b0, 32'd10});
        step();
        check_drain("pass_exit", 1'b0);

        // Failing exit with ignore rules; random non-tohost stores must not stop
        do_reset();
        run_to(32'd4);
        drive_store(TOHOST, 32'h2);
        step();
        chk("even_store_ignored", 72'(halt), 72'd0);
        drive_store(32'($urandom_range(0, 32'h0FFF)), 32'h1);
        step();
        chk("other_addr_ignored", 72'(halt), 72'd0);
        drive_idle();
        run_to(32'd7);
        drive_store(TOHOST, 32'h7);
        exp_q.push_back({31'd3, 1'b0, 1'b0, 32'd8});
        step();
        check_drain("fail_exit", 1'b1);

        // Watchdog at 50 cycles
        do_reset();
        exp_q.push_back({31'd0, 1'b0, 1'b1, 32'd50});
        n = 0;
        while (!halt && n < 100) begin
            step();
            n++;
        end
        chk("wdog_latency", 72'(n), 72'd50);
        check_drain("wdog", 1'b0);

        // Exit store and external request on the same edge
        do_reset();
        run_to(32'd20);
        drive_store(TOHOST, 32'h5);
        ext_halt_req = 1'b1;
        exp_q.push_back({31'd2, 1'b0, 1'b0, 32'd21});
        step();
        check_drain("exit_vs_ext", 1'b0);

        // Exit store on the watchdog edge
        do_reset();
        run_to(32'd49);
        drive_store(TOHOST, 32'h9);
        exp_q.push_back({31'd4, 1'b0, 1'b0, 32'd50});
        step();
        check_drain("exit_vs_wdog", 1'b0);

        // External request on the watchdog edge
        do_reset();
        run_to(32'd49);
        ext_halt_req = 1'b1;
        exp_q.push_back({31'd0, 1'b0, 1'b0, 32'd50});
        step();
        check_drain("ext_vs_wdog", 1'b0);

        // Reset one cycle into DRAIN
        do_reset();
        run_to(32'd5);
        ext_halt_req = 1'b1;
        step();
        drive_idle();
        chk("mid_drain_halt", 72'({halt, cycle_count}), 72'({1'b1, 32'd6}));
        rst = 1'b1;
        #1;
        chk("async_reset", 72'({halt, done, exit_code, pass, timeout, cycle_count}), 72'd0);
        step();
        rst = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            step();
            chk("fresh_run", 72'({halt, done, cycle_count}), 72'({2'b00, 32'(k)}));
        end

        // Disabled watchdog instance: no halt across 10000 cycles
        n = 0;
        while (cycle_count_z < 32'd10000 && n < 20000) begin
            step();
            n++;
        end
        chk("nowdog_count", 72'(cycle_count_z), 72'(z_edges));
        chk("nowdog_outs", 72'({z_seen_halt, halt_z, done_z, exit_code_z, pass_z, timeout_z}), 72'd0);
        chk("nowdog_reached", 72'(cycle_count_z >= 32'd10000), 72'd1);

        chk("queue_drained", 72'(exp_q.size()), 72'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
